regfile_2r1w: RTL and testbench
===============================

# regfile_2r1w

Parametrised two-read/one-write register file: the next generation of the team's 8×32 single-port-read register file. Width and depth are set by parameters. Two independent combinational read ports carry same-cycle write bypass. Writes take per-byte enables. An optional hardwired-zero entry 0 is available. A sequential bulk-clear engine zeroes the array one entry per cycle under a busy flag. The block sits in the datapath as the general-purpose register array feeding the ALU operand muxes.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; power of two, ≥2. Local AW = clog2(DEPTH), NB = WIDTH/8.
- ZERO_REG, 0, when 1, entry 0 always reads zero and writes to it are discarded.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- wAddr  in  AW  write address.
- wData  in  WIDTH  write data.
- wBe  in  NB  byte enables; bit i gates wData[8i+7:8i].
- rAddrA, rAddrB  in  AW  read addresses.
- rDataA, rDataB  out  WIDTH  read data (combinational).
- clr  in  1  bulk-clear request (level sampled).
- busy  out  1  registered; high while clear in progress.

## Operation
- Reset (reset_n=0, asynchronous): all entries to 0; FSM to IDLE; clear counter to 0; busy=0. Read outputs therefore show 0 during reset.
- Write: in IDLE, at a rising edge with we=1, each byte i of entry wAddr with wBe[i]=1 takes wData byte i. Other bytes are kept. wBe=0 is a no-op.
- Read: rDataX = stored entry[rAddrX], with bypass. If we=1, busy=0 and wAddr==rAddrX, the enabled bytes come from wData and the remaining bytes come from storage. Both ports bypass independently, including when rAddrA==rAddrB.
- ZERO_REG=1: a read of address 0 returns 0 regardless of bypass. A write to address 0 is ignored.
- Clear FSM states IDLE, CLEAR:
  - IDLE→CLEAR when clr=1 at an edge. A write in that same cycle is still performed and is later zeroed by the sweep.
  - In CLEAR, each edge zeroes entry[cnt] and increments cnt.
  - CLEAR→IDLE at the edge that zeroes entry DEPTH-1; cnt wraps to 0.
- While busy=1:
  - we is ignored: no storage update and no bypass.
  - clr is ignored.
  - Reads return current storage, i.e. partially cleared contents.
- Reset during CLEAR aborts the sweep. The array is fully zeroed by reset anyway.

## Timing
- Write latency: storage updated at the edge where we=1. The bypass makes the data visible on the read ports in the same cycle.
- Read latency: 0 cycles (combinational from rAddr, we, wAddr, wData, wBe).
- Clear: clr sampled at edge k → busy=1 after edge k. Entries 0..DEPTH-1 are zeroed at edges k+1..k+DEPTH. busy=0 after edge k+DEPTH. Total of DEPTH busy cycles.
- clr held high continuously starts a new sweep at the first IDLE edge, i.e. back-to-back sweeps separated by one idle cycle.
- No combinational path from any input to busy.

## Structure
- Package regfile_pkg holds:
  - the state enum {IDLE, CLEAR};
  - a byte-merge function (old, new, be) → merged word, used by both the storage write and the bypass.
- Sub-module regfile_clear_ctrl holds the FSM, AW-bit counter and busy register. It outputs busy, clr_we and clr_addr.
- Top level holds the storage array, write decode with byte enables, and the two read muxes with bypass.

## Test plan
- Reset then read all addresses on both ports → rDataA=rDataB=0. busy=0.
- Write 0xDEADBEEF to addr 3 with wBe=4'hF. Next cycle write 0x000000AA with wBe=4'b0001. Read addr 3 → 0xDEADBEAA.
- Same-cycle bypass: storage[5]=0x11223344. Drive we=1, wAddr=5, wData=0xAABBCCDD, wBe=4'b1100, rAddrA=rAddrB=5 → both read 0xAABB3344 before the edge.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0 → reads of addr 0 return 0, including in the bypass cycle.
- Fill all entries with nonzero data, pulse clr for 1 cycle.
  - busy must stay high for exactly DEPTH cycles.
  - The entries must zero in ascending order.
  - A write issued mid-sweep must be discarded.
  - All reads must return 0 after busy falls.
- Assert reset_n=0 asynchronously mid-sweep (between edges) → busy and all reads go 0 immediately. After release, a write/read works in IDLE.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the two-read/one-write register file.
// Byte-merge works on a capped width so any WIDTH up to MAX_W can use it.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int MAX_W  = 256;
    localparam int MAX_NB = MAX_W / 8;

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_NB-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Bulk-clear sequencer: walks the array one entry per cycle under busy.
// busy is a pure register, so no input reaches it combinationally.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_2r1w.sv
// General-purpose register array: two bypassed read ports, one byte-masked
// write port, optional hardwired-zero entry 0 and a sequential bulk clear.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    wAddr,
    input  logic [WIDTH-1:0] wData,
    input  logic [NB-1:0]    wBe,
    input  logic [AW-1:0]    rAddrA,
    input  logic [AW-1:0]    rAddrB,
    output logic [WIDTH-1:0] rDataA,
    output logic [WIDTH-1:0] rDataB,
    input  logic             clr,
    output logic             busy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             wr_live;
    logic             wr_en;
    logic [WIDTH-1:0] wr_word;
    logic             byp_a;
    logic             byp_b;
    logic             zro_a;
    logic             zro_b;

    regfile_clear_ctrl #(
        .DEPTH(DEPTH)
    ) u_clear_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // A write is only live while idle; it drives both storage and bypass.
    assign wr_live = we && !busy;
    assign wr_en   = wr_live && !(ZERO_REG && (wAddr == '0));

    assign wr_word = WIDTH'(byte_merge(MAX_W'(mem[wAddr]),
                                       MAX_W'(wData),
                                       MAX_NB'(wBe)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[wAddr] <= wr_word;
        end
    end

    assign byp_a = wr_live && (wAddr == rAddrA);
    assign byp_b = wr_live && (wAddr == rAddrB);
    assign zro_a = ZERO_REG && (rAddrA == '0);
    assign zro_b = ZERO_REG && (rAddrB == '0);

    assign rDataA = zro_a ? '0 :
                    byp_a ? WIDTH'(byte_merge(MAX_W'(mem[rAddrA]),
                                              MAX_W'(wData),
                                              MAX_NB'(wBe))) :
                    mem[rAddrA];

    assign rDataB = zro_b ? '0 :
                    byp_b ? WIDTH'(byte_merge(MAX_W'(mem[rAddrB]),
                                              MAX_W'(wData),
                                              MAX_NB'(wBe))) :
                    mem[rAddrB];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: one instance without and one with the zero entry,
// driven in lockstep and checked against an array-level reference model.
module tb_regfile_2r1w;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  wAddr = '0;
    logic [31:0] wData = '0;
    logic [3:0]  wBe = '0;
    logic [2:0]  rAddrA = '0;
    logic [2:0]  rAddrB = '0;
    logic        clr = 1'b0;
    logic [31:0] rd0a, rd0b, rd1a, rd1b;
    logic        busy0, busy1;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] m0 [DEPTH] = '{default: 32'h0};
    logic [31:0] m1 [DEPTH] = '{default: 32'h0};
    int sweep_left = 0;

    regfile_2r1w #(.WIDTH(32), .DEPTH(DEPTH), .ZERO_REG(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr),
        .wData(wData), .wBe(wBe), .rAddrA(rAddrA), .rAddrB(rAddrB),
        .rDataA(rd0a), .rDataB(rd0b), .clr(clr), .busy(busy0)
    );

    regfile_2r1w #(.WIDTH(32), .DEPTH(DEPTH), .ZERO_REG(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr),
        .wData(wData), .wBe(wBe), .rAddrA(rAddrA), .rAddrB(rAddrB),
        .rDataA(rd1a), .rDataB(rd1b), .clr(clr), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m = m | (32'hFF << (8 * i));
        end
        return m;
    endfunction

    function automatic logic [31:0] exp_read(input bit z,
                                             input logic [2:0] a);
        logic [31:0] v;
        logic [31:0] msk;
        if (z && a == 3'd0) return 32'h0;
        v = z ? m1[a] : m0[a];
        if (we && sweep_left == 0 && wAddr == a) begin
            msk = be_mask(wBe);
            v = (v & ~msk) | (wData & msk);
        end
        return v;
    endfunction

    // Reference model: storage as plain arrays, clear as a countdown.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m0[i] = 32'h0;
                m1[i] = 32'h0;
            end
            sweep_left = 0;
        end else if (sweep_left > 0) begin
            m0[DEPTH - sweep_left] = 32'h0;
            m1[DEPTH - sweep_left] = 32'h0;
            sweep_left = sweep_left - 1;
        end else begin
            if (we) begin
                m0[wAddr] = (m0[wAddr] & ~be_mask(wBe)) |
                            (wData & be_mask(wBe));
                if (wAddr != 3'd0)
                    m1[wAddr] = (m1[wAddr] & ~be_mask(wBe)) |
                                (wData & be_mask(wBe));
            end
            if (clr) sweep_left = DEPTH;
        end
    end

    always @(negedge clk) begin
        chk("u0.rDataA", rd0a, exp_read(1'b0, rAddrA));
        chk("u0.rDataB", rd0b, exp_read(1'b0, rAddrB));
        chk("u1.rDataA", rd1a, exp_read(1'b1, rAddrA));
        chk("u1.rDataB", rd1b, exp_read(1'b1, rAddrB));
        chk("u0.busy", 32'(busy0), 32'(sweep_left > 0));
        chk("u1.busy", 32'(busy1), 32'(sweep_left > 0));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        we = 1'b1;
        wAddr = a;
        wData = d;
        wBe = be;
        cyc();
        we = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] fill [DEPTH];
        for (int i = 0; i < DEPTH; i++) fill[i] = 32'h11111111 * (i + 1);

        repeat (3) cyc();
        reset_n = 1'b1;
        chk("busy_after_reset", 32'(busy0), 32'h0);
        for (int a = 0; a < DEPTH; a++) begin
            rAddrA = 3'(a);
            rAddrB = 3'(DEPTH - 1 - a);
            #1;
            chk("reset_read_a", rd0a, 32'h0);
            chk("reset_read_b", rd0b, 32'h0);
            cyc();
        end

        wr(3'd3, 32'hDEADBEEF, 4'hF);
        wr(3'd3, 32'h000000AA, 4'b0001);
        rAddrA = 3'd3;
        #1;
        chk("byte_write", rd0a, 32'hDEADBEAA);
        wr(3'd3, 32'h55555555, 4'h0);
        #1;
        chk("be_zero_noop", rd0a, 32'hDEADBEAA);

        wr(3'd5, 32'h11223344, 4'hF);
        we = 1'b1;
        wAddr = 3'd5;
        wData = 32'hAABBCCDD;
        wBe = 4'b1100;
        rAddrA = 3'd5;
        rAddrB = 3'd5;
        #1;
        chk("bypass_a", rd0a, 32'hAABB3344);
        chk("bypass_b", rd0b, 32'hAABB3344);
        chk("bypass_z1", rd1b, 32'hAABB3344);
        cyc();
        we = 1'b0;
        #1;
        chk("after_bypass", rd0a, 32'hAABB3344);

        we = 1'b1;
        wAddr = 3'd0;
        wData = 32'hFFFFFFFF;
        wBe = 4'hF;
        rAddrA = 3'd0;
        #1;
        chk("zero_reg_bypass", rd1a, 32'h0);
        chk("no_zero_bypass", rd0a, 32'hFFFFFFFF);
        cyc();
        we = 1'b0;
        #1;
        chk("zero_reg_store", rd1a, 32'h0);
        chk("no_zero_store", rd0a, 32'hFFFFFFFF);

        for (int i = 0; i < DEPTH; i++) wr(3'(i), fill[i], 4'hF);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n = 0;
        while (busy0 && n < 20) begin
            if (n > 0) rAddrA = 3'(n - 1);
            if (n < DEPTH) rAddrB = 3'(n);
            if (n == 3) begin
                we = 1'b1;
                wAddr = 3'd2;
                wData = 32'h12345678;
                wBe = 4'hF;
            end
            #1;
            if (n > 0) chk("sweep_cleared", rd0a, 32'h0);
            if (n < DEPTH) chk("sweep_pending", rd0b, fill[n]);
            cyc();
            we = 1'b0;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) begin
            rAddrA = 3'(a);
            rAddrB = 3'(a);
            #1;
            chk("post_clear_u0", rd0a, 32'h0);
            chk("post_clear_u1", rd1b, 32'h0);
        end

        wr(3'd4, 32'h0BADCAFE, 4'hF);
        clr = 1'b1;
        repeat (20) cyc();
        clr = 1'b0;
        n = 0;
        while (busy0 && n < 20) begin
            cyc();
            n++;
        end
        chk("held_clr_end", 32'(busy0), 32'h0);

        wr(3'd1, 32'hA1A1A1A1, 4'hF);
        wr(3'd6, 32'hB2B2B2B2, 4'hF);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc();
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_busy_u0", 32'(busy0), 32'h0);
        chk("async_busy_u1", 32'(busy1), 32'h0);
        for (int a = 0; a < DEPTH; a++) begin
            rAddrA = 3'(a);
            rAddrB = 3'(DEPTH - 1 - a);
            #1;
            chk("async_read_a", rd0a, 32'h0);
            chk("async_read_b", rd0b, 32'h0);
        end
        cyc();
        reset_n = 1'b1;
        wr(3'd6, 32'hCAFEF00D, 4'hF);
        rAddrA = 3'd6;
        #1;
        chk("post_reset_write", rd0a, 32'hCAFEF00D);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
